// File: rtl/load_pattern_v1.sv
// load_pattern_v1: sequences pattern frames from a first-word-fall-through
// source FIFO into a destination FIFO. An optional all-ones frame goes in
// front and an optional all-zeros frame goes at the end. Each sequence starts
// after a fixed idle preamble, and configuration is captured once per sequence.
module load_pattern_v1 #(
  parameter int DATA_W  = 256,
  parameter int CNT_W   = 32,
  parameter int PRE_DLY = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  num_streams,
  input  logic [CNT_W-1:0]  num_pat,
  input  logic              mode_ones,
  input  logic              mode_zeros,
  input  logic [DATA_W-1:0] pat_in,
  input  logic              camfifo_valid,
  output logic              pat_fifo_rd_en,
  input  logic              FIFO_full,
  output logic              FIFO_wr,
  output logic [DATA_W-1:0] Pat_out,
  output logic              busy,
  output logic              frame_done,
  output logic              seq_done
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_PRE   = 3'd1,
    S_ONES  = 3'd2,
    S_PATS  = 3'd3,
    S_ZEROS = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  sh_streams_q, sh_streams_d;
  logic [CNT_W-1:0]  sh_pat_q, sh_pat_d;
  logic              sh_ones_q, sh_ones_d;
  logic              sh_zeros_q, sh_zeros_d;
  logic              wr_d, frame_done_d, seq_done_d, xfer;
  logic [DATA_W-1:0] pat_out_d;

  // First write state after the preamble. An empty frame size skips every
  // writing state, so the counters never see a zero-length frame.
  function automatic state_t after_pre(input logic [CNT_W-1:0] streams,
                                       input logic [CNT_W-1:0] pats,
                                       input logic ones, input logic zeros);
    if (streams == '0)    return S_DONE;
    else if (ones)        return S_ONES;
    else if (pats != '0)  return S_PATS;
    else if (zeros)       return S_ZEROS;
    else                  return S_DONE;
  endfunction

  // Next state once the all-ones frame is finished.
  function automatic state_t after_ones(input logic [CNT_W-1:0] pats,
                                        input logic zeros);
    if (pats != '0)  return S_PATS;
    else if (zeros)  return S_ZEROS;
    else             return S_DONE;
  endfunction

  // Next-state, counter and output-register logic.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path
    // can leave one unassigned and infer a latch.
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    pre_cnt_d    = pre_cnt_q;
    sh_streams_d = sh_streams_q;
    sh_pat_d     = sh_pat_q;
    sh_ones_d    = sh_ones_q;
    sh_zeros_d   = sh_zeros_q;
    wr_d         = 1'b0;
    pat_out_d    = Pat_out;
    frame_done_d = 1'b0;
    seq_done_d   = 1'b0;
    xfer         = 1'b0;

    case (state_q)
      S_INIT: begin
        if (en && !FIFO_full) begin
          sh_streams_d = num_streams;
          sh_pat_d     = num_pat;
          sh_ones_d    = mode_ones;
          sh_zeros_d   = mode_zeros;
          word_cnt_d   = '0;
          frame_cnt_d  = '0;
          pre_cnt_d    = '0;
          state_d      = (PRE_DLY == 0) ?
                         after_pre(num_streams, num_pat, mode_ones, mode_zeros) : S_PRE;
        end
      end
      S_PRE: begin
        if (pre_cnt_q == CNT_W'(PRE_DLY - 1))
          state_d = after_pre(sh_streams_q, sh_pat_q, sh_ones_q, sh_zeros_q);
        else
          pre_cnt_d = pre_cnt_q + CNT_W'(1);
      end
      S_ONES, S_ZEROS: begin
        if (!FIFO_full) begin
          wr_d      = 1'b1;
          pat_out_d = (state_q == S_ONES) ? '1 : '0;
          if (word_cnt_q + CNT_W'(1) == sh_streams_q) begin
            word_cnt_d = '0;
            state_d    = (state_q == S_ONES) ? after_ones(sh_pat_q, sh_zeros_q) : S_DONE;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
      S_PATS: begin
        xfer = camfifo_valid && !FIFO_full && (word_cnt_q != sh_streams_q);
        if (xfer) begin
          wr_d      = 1'b1;
          pat_out_d = pat_in;
          if (word_cnt_q + CNT_W'(1) == sh_streams_q) begin
            word_cnt_d   = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            if (frame_cnt_q + CNT_W'(1) == sh_pat_q)
              state_d = sh_zeros_q ? S_ZEROS : S_DONE;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        seq_done_d = 1'b1;
        state_d    = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Source pop and busy are masked while reset is held.
  assign pat_fifo_rd_en = xfer && !rst;
  assign busy           = !rst && (state_q != S_INIT);

  // State, counters, shadow configuration and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (rst) begin
      state_q      <= S_INIT;
      word_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      pre_cnt_q    <= '0;
      sh_streams_q <= '0;
      sh_pat_q     <= '0;
      sh_ones_q    <= 1'b0;
      sh_zeros_q   <= 1'b0;
      FIFO_wr      <= 1'b0;
      Pat_out      <= '0;
      frame_done   <= 1'b0;
      seq_done     <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      pre_cnt_q    <= pre_cnt_d;
      sh_streams_q <= sh_streams_d;
      sh_pat_q     <= sh_pat_d;
      sh_ones_q    <= sh_ones_d;
      sh_zeros_q   <= sh_zeros_d;
      FIFO_wr      <= wr_d;
      Pat_out      <= pat_out_d;
      frame_done   <= frame_done_d;
      seq_done     <= seq_done_d;
    end
  end

endmodule

// File: tb/tb_load_pattern_v1.sv
// tb_load_pattern_v1: models the sequence as an ordered list of expected
// destination words (ones frame, source words in order, zeros frame) and a
// set of pulse counts, then compares the DUT against that list every cycle.
module tb_load_pattern_v1;

  localparam int DATA_W = 256;
  localparam int CNT_W  = 32;
  localparam int SRC_N  = 256;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                is_src;
  } exp_t;

  logic              clk, rst, en, mode_ones, mode_zeros;
  logic [CNT_W-1:0]  num_streams, num_pat;
  logic [DATA_W-1:0] pat_in, Pat_out;
  logic              camfifo_valid, pat_fifo_rd_en, FIFO_full, FIFO_wr;
  logic              busy, frame_done, seq_done;

  load_pattern_v1 dut (
    .clk(clk), .rst(rst), .en(en), .num_streams(num_streams), .num_pat(num_pat),
    .mode_ones(mode_ones), .mode_zeros(mode_zeros), .pat_in(pat_in),
    .camfifo_valid(camfifo_valid), .pat_fifo_rd_en(pat_fifo_rd_en),
    .FIFO_full(FIFO_full), .FIFO_wr(FIFO_wr), .Pat_out(Pat_out), .busy(busy),
    .frame_done(frame_done), .seq_done(seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  logic [DATA_W-1:0] src_mem [SRC_N];
  int src_idx = 0;
  exp_t exp_q[$];
  logic [DATA_W-1:0] last_out = '0;
  int n_wr, n_frame, n_seq, n_rd, src_wr, cur_streams;
  int cyc = 0, en_cyc = 0, first_cyc = -1;
  bit en_prev = 1'b0, rst_prev = 1'b1;
  int valid_mode = 0;
  bit rand_full = 1'b0, stall_test = 1'b0, stall_started = 1'b0, valid_gate = 1'b0;
  int full_hold = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Source FIFO and destination back-pressure, updated just after each edge.
  always @(posedge clk) begin
    #1;
    if (stall_test && n_wr >= 2 && !stall_started) begin
      full_hold     = 5;
      stall_started = 1'b1;
    end
    FIFO_full = (full_hold > 0) || (rand_full && ($urandom_range(0, 3) == 0));
    if (full_hold > 0) full_hold--;
    case (valid_mode)
      0:       valid_gate = 1'b1;
      1:       valid_gate = ~valid_gate;
      default: valid_gate = ($urandom_range(0, 2) != 0);
    endcase
    camfifo_valid = valid_gate && (src_idx < SRC_N);
    pat_in        = (src_idx < SRC_N) ? src_mem[src_idx] : '0;
  end

  // Compare process: runs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (en && !en_prev) en_cyc = cyc;
    en_prev = en;
    if (rst_prev) begin
      check("reset_wr", DATA_W'(FIFO_wr), '0);
      check("reset_out", Pat_out, '0);
      check("reset_pulses", DATA_W'({frame_done, seq_done}), '0);
      exp_q.delete();
      last_out = '0;
    end else begin
      if (FIFO_wr) begin
        if (n_wr == 0) first_cyc = cyc;
        n_wr++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", Pat_out, '0);
          if (Pat_out === '0) check("unexpected_write_strobe", DATA_W'(FIFO_wr), '0);
        end else begin
          e = exp_q.pop_front();
          check("write_data", Pat_out, e.data);
          if (e.is_src) src_wr++;
          last_out = e.data;
        end
      end else begin
        check("hold_out", Pat_out, last_out);
      end
      if (frame_done) begin
        n_frame++;
        check("frame_done_align",
              DATA_W'(FIFO_wr && cur_streams != 0 && src_wr != 0 && (src_wr % cur_streams) == 0),
              DATA_W'(1));
      end
      if (seq_done) n_seq++;
    end
    if (rst) check("reset_comb", DATA_W'({busy, pat_fifo_rd_en}), '0);
    if (pat_fifo_rd_en) begin
      n_rd++;
      check("rd_legal", DATA_W'(camfifo_valid && !FIFO_full), DATA_W'(1));
      src_idx++;
    end
    rst_prev = rst;
  end

  // Starts one sequence: builds the expected word list, pulses en until the
  // block goes busy, then waits for seq_done and checks the totals.
  task automatic start_seq(input int ns, input int np, input bit mo, input bit mz,
                           input int vmode, input bit rfull, input bit stall);
    @(posedge clk); #1;
    valid_mode = vmode; rand_full = rfull; stall_test = stall; stall_started = 1'b0;
    num_streams = CNT_W'(ns); num_pat = CNT_W'(np);
    mode_ones = mo; mode_zeros = mz; en = 1'b1;
    cur_streams = ns;
    n_wr = 0; n_frame = 0; n_seq = 0; n_rd = 0; src_wr = 0; first_cyc = -1;
    if (ns != 0) begin
      if (mo) for (int i = 0; i < ns; i++) exp_q.push_back('{data: '1, is_src: 1'b0});
      for (int i = 0; i < ns * np; i++)
        exp_q.push_back('{data: src_mem[src_idx + i], is_src: 1'b1});
      if (mz) for (int i = 0; i < ns; i++) exp_q.push_back('{data: '0, is_src: 1'b0});
    end
    for (int i = 0; i < 50 && en; i++) begin
      @(posedge clk); #1;
      if (busy) en = 1'b0;
    end
    if (en) begin
      check("start_timeout", DATA_W'(busy), DATA_W'(1));
      en = 1'b0;
    end
  endtask

  task automatic run_seq(input int ns, input int np, input bit mo, input bit mz,
                         input int vmode, input bit rfull, input bit stall, input bit chg);
    int tot;
    start_seq(ns, np, mo, mz, vmode, rfull, stall);
    for (int i = 0; i < 3000 && n_seq == 0; i++) begin
      @(posedge clk); #1;
      if (chg && i == 10) num_streams = CNT_W'(7);
    end
    check("seq_done_seen", DATA_W'(n_seq != 0), DATA_W'(1));
    repeat (3) @(posedge clk);
    #1;
    tot = (ns == 0) ? 0 : ns * (np + int'(mo) + int'(mz));
    check("total_writes", DATA_W'(n_wr), DATA_W'(tot));
    check("queue_drained", DATA_W'(exp_q.size()), '0);
    check("frame_count", DATA_W'(n_frame), DATA_W'((ns == 0) ? 0 : np));
    check("seq_count", DATA_W'(n_seq), DATA_W'(1));
    check("read_count", DATA_W'(n_rd), DATA_W'(ns * np));
    check("idle_after", DATA_W'(busy), '0);
    rand_full = 1'b0; stall_test = 1'b0; valid_mode = 0;
  endtask

  initial begin
    int wr_after;
    for (int i = 0; i < SRC_N; i++)
      for (int k = 0; k < DATA_W / 32; k++) src_mem[i][k*32 +: 32] = $urandom;
    rst = 1'b1; en = 1'b0; num_streams = '0; num_pat = '0;
    mode_ones = 1'b0; mode_zeros = 1'b0; FIFO_full = 1'b0;
    camfifo_valid = 1'b0; pat_in = '0;
    n_wr = 0; n_frame = 0; n_seq = 0; n_rd = 0; src_wr = 0; cur_streams = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_reset", DATA_W'({busy, FIFO_wr, frame_done, seq_done}), '0);

    // Basic sequence, with latency and pulse counts pinned to literals.
    run_seq(4, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("basic_writes", DATA_W'(n_wr), DATA_W'(8));
    check("basic_frames", DATA_W'(n_frame), DATA_W'(2));
    check("basic_latency", DATA_W'(first_cyc - en_cyc), DATA_W'(7));

    // Mode frames around a single pattern frame.
    run_seq(3, 1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("mode_writes", DATA_W'(n_wr), DATA_W'(9));

    // Alternating valid plus a five-cycle full window mid-frame.
    run_seq(4, 2, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
    check("stall_reads", DATA_W'(n_rd), DATA_W'(8));
    check("stall_writes", DATA_W'(n_wr), DATA_W'(8));

    // Degenerate counts.
    run_seq(2, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("np0_writes", DATA_W'(n_wr), DATA_W'(2));
    check("np0_frames", DATA_W'(n_frame), '0);
    run_seq(0, 2, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("ns0_writes", DATA_W'(n_wr), '0);
    check("ns0_seq", DATA_W'(n_seq), DATA_W'(1));

    // Reset one cycle after the second word of a four-word frame.
    start_seq(4, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 200 && n_wr < 2; i++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wr_after = n_wr;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_seq_done", DATA_W'(n_seq), '0);
    check("abort_no_writes", DATA_W'(n_wr), DATA_W'(wr_after));
    check("abort_idle", DATA_W'(busy), '0);
    run_seq(4, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Configuration isolation: the change to 7 lands mid-sequence.
    run_seq(4, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("iso_first_writes", DATA_W'(n_wr), DATA_W'(8));
    run_seq(7, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("iso_second_writes", DATA_W'(n_wr), DATA_W'(14));

    // Randomized sequences with random valid and back-pressure.
    for (int t = 0; t < 6; t++)
      run_seq(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/load_pattern_v1.md
LOAD_PATTERN_V1 -- requirements
Module: load_pattern_v1

Interface
REQ-001 SHALL have parameter DATA_W, default 256, pattern word width in bits.
REQ-002 SHALL have parameter CNT_W, default 32, width of all counters and count inputs.
REQ-003 SHALL have parameter PRE_DLY, default 5, idle cycles inserted before each sequence.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  sequence enable, level.
REQ-007 SHALL have port num_streams  input  CNT_W  words per pattern frame.
REQ-008 SHALL have port num_pat  input  CNT_W  pattern frames per sequence.
REQ-009 SHALL have port mode_ones  input  1  prepend one all-ones frame.
REQ-010 SHALL have port mode_zeros  input  1  append one all-zeros frame.
REQ-011 SHALL have port pat_in  input  DATA_W  source FIFO data, first-word-fall-through.
REQ-012 SHALL have port camfifo_valid  input  1  pat_in holds valid data.
REQ-013 SHALL have port pat_fifo_rd_en  output  1  source pop, combinational.
REQ-014 SHALL have port FIFO_full  input  1  destination almost-full, at least 1 word of slack.
REQ-015 SHALL have port FIFO_wr  output  1  destination write strobe, registered.
REQ-016 SHALL have port Pat_out  output  DATA_W  destination data, registered.
REQ-017 SHALL have port busy  output  1  high in every state except S_INIT.
REQ-018 SHALL have port frame_done  output  1  one-cycle pulse per completed pattern frame.
REQ-019 SHALL have port seq_done  output  1  one-cycle pulse per completed sequence.

Function
REQ-020 SHALL implement states S_INIT, S_PRE, S_ONES, S_PATS, S_ZEROS, S_DONE.
REQ-021 S_INIT: when en=1 and FIFO_full=0, SHALL latch num_streams, num_pat, mode_ones and mode_zeros into shadow registers, clear counters and go to S_PRE. Mid-sequence input changes SHALL be ignored.
REQ-022 S_PRE: SHALL wait exactly PRE_DLY cycles with no writes, then go to S_ONES if mode_ones, else to S_PATS.
REQ-023 S_ONES: each cycle with FIFO_full=0 SHALL write one all-ones word. After num_streams words it SHALL go to S_PATS.
REQ-024 S_PATS: a transfer occurs in a cycle where camfifo_valid=1, FIFO_full=0 and word count < num_streams.
REQ-025 On a transfer, pat_fifo_rd_en SHALL be 1 in the same cycle. On the next cycle, FIFO_wr SHALL be 1 and Pat_out SHALL equal pat_in.
REQ-026 S_PATS: when camfifo_valid=0 or FIFO_full=1, the block SHALL stall with no read and no write. The frame SHALL NOT be aborted and the counters SHALL hold.
REQ-027 When the word count reaches num_streams, frame_done SHALL pulse, the word count SHALL clear and the frame count SHALL increment. When the frame count reaches num_pat, the block SHALL go to S_ZEROS if mode_zeros, else to S_DONE.
REQ-028 S_ZEROS: SHALL behave like S_ONES but write all-zeros words, then go to S_DONE.
REQ-029 S_DONE: seq_done SHALL pulse for one cycle and the block SHALL return to S_INIT.
REQ-030 Only in S_PATS SHALL pat_fifo_rd_en be asserted. FIFO_wr SHALL never be asserted in S_INIT, S_PRE or S_DONE.
REQ-031 Pat_out SHALL hold its last value when FIFO_wr=0.
REQ-032 If num_pat=0, S_PATS SHALL be skipped.
REQ-033 If num_streams=0, S_ONES, S_PATS and S_ZEROS SHALL perform no writes and no frame_done pulses; seq_done SHALL still pulse.
REQ-034 Counters SHALL be CNT_W bits, unsigned. Comparisons SHALL use equality to the shadow values so that no wrap-around occurs.
REQ-035 An unreachable state encoding SHALL return to S_INIT on the next cycle.

Reset
REQ-036 While rst=1, on each rising edge the block SHALL set state=S_INIT, counters=0, Pat_out=0, FIFO_wr=0, frame_done=0, seq_done=0.
REQ-037 While rst=1, pat_fifo_rd_en SHALL be 0 and busy SHALL be 0.
REQ-038 A reset mid-sequence SHALL abandon the sequence with no further writes or pulses. A new sequence SHALL start only from S_INIT.

Verification
REQ-039 Basic sequence: num_streams=4, num_pat=2, both modes 0, camfifo_valid held 1 -> 8 writes matching the pat_in order, frame_done pulses at words 4 and 8, one seq_done pulse, first write PRE_DLY+2 cycles after en.
REQ-040 Mode frames: num_streams=3, num_pat=1, mode_ones=1, mode_zeros=1 -> writes of 3 all-ones, then 3 source words, then 3 all-zeros words; 9 FIFO_wr pulses total.
REQ-041 Stalls: camfifo_valid toggled 1010..., FIFO_full forced high for 5 cycles mid-frame -> no lost or duplicated words; pat_fifo_rd_en count equals FIFO_wr count in S_PATS (8 each for num_streams=4, num_pat=2).
REQ-042 Degenerate counts: num_pat=0 with mode_zeros=1, num_streams=2 -> exactly 2 zero writes, zero frame_done pulses, one seq_done pulse. num_streams=0 -> zero writes, one seq_done pulse.
REQ-043 Reset mid-frame: rst=1 for 1 cycle after the 2nd word of 4 -> FIFO_wr=0 and Pat_out=0 next cycle, no seq_done pulse; a restart yields a full, correct sequence.
REQ-044 Config isolation: num_streams changed from 4 to 7 mid-sequence -> the current sequence uses 4; the following sequence uses 7.
